// File: rtl/sram_responder.sv
// Purpose: serves single-word read/write requests from the control unit against an
//          asynchronous SRAM with a fixed number of access cycles. One pending slot
//          absorbs a request that arrives while busy; further requests are dropped
//          and flagged on a sticky overrun bit.
// Ports:
//   clk, n_rst                     clock, asynchronous active-low reset
//   i_re, i_raddr                  read request pulse and word address
//   i_we, i_waddr, i_wdata         write request pulse, word address and data
//   i_sram_rdata                   SRAM read data bus
//   o_read_complete, o_rdata       read done pulse and captured read word
//   o_write_complete               write done pulse
//   o_sram_addr, o_sram_wdata      SRAM address and write data
//   o_sram_ce, o_sram_oe, o_sram_wr SRAM strobes, active-high
//   o_overrun                      sticky dropped-request flag
//   o_busy                         high whenever the FSM is not idle
module sram_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] RD_BASE     = 32'h0000_0000,
    parameter logic [31:0] WR_BASE     = 32'h0010_0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        i_re,
    input  logic [31:0] i_raddr,
    input  logic        i_we,
    input  logic [31:0] i_waddr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_sram_rdata,
    output logic        o_read_complete,
    output logic [31:0] o_rdata,
    output logic        o_write_complete,
    output logic [31:0] o_sram_addr,
    output logic        o_sram_ce,
    output logic        o_sram_oe,
    output logic        o_sram_wr,
    output logic [31:0] o_sram_wdata,
    output logic        o_overrun,
    output logic        o_busy
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned DATA_W   = 32;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        RD_DONE,
        WR_ACCESS,
        WR_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_vld_q, pend_vld_d;
    logic                pend_wr_q, pend_wr_d;
    logic [DATA_W-1:0]   pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                overrun_q, overrun_d;
    logic                ce_q, oe_q, wr_q, rd_cmp_q, wr_cmp_q, busy_q;

    // Candidate request from the inputs; a read wins over a simultaneous write
    logic                req_vld, req_wr;
    logic [DATA_W-1:0]   req_addr, req_data;
    // Transfer to start on this edge
    logic                srv_vld, srv_wr;
    logic [DATA_W-1:0]   srv_addr, srv_data;

    // Next-state, slot management and access launch
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_wr_d   = pend_wr_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        overrun_d   = overrun_q;
        srv_vld     = 1'b0;
        srv_wr      = 1'b0;
        srv_addr    = '0;
        srv_data    = '0;

        req_vld  = i_re | i_we;
        req_wr   = ~i_re & i_we;
        req_addr = i_re ? i_raddr : i_waddr;
        req_data = i_re ? '0 : i_wdata;

        // Busy: park one request in the slot, drop anything else
        if (state_q != IDLE && req_vld) begin
            if (pend_vld_q) begin
                overrun_d = 1'b1;
            end else begin
                pend_vld_d  = 1'b1;
                pend_wr_d   = req_wr;
                pend_addr_d = req_addr;
                pend_data_d = req_data;
                if (i_re && i_we) overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (req_vld) begin
                    srv_vld  = 1'b1;
                    srv_wr   = req_wr;
                    srv_addr = req_addr;
                    srv_data = req_data;
                    // Read goes first; the simultaneous write waits in the slot
                    if (i_re && i_we) begin
                        pend_vld_d  = 1'b1;
                        pend_wr_d   = 1'b1;
                        pend_addr_d = i_waddr;
                        pend_data_d = i_wdata;
                    end
                end
            end
            RD_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    rdata_d = i_sram_rdata;
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = WR_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RD_DONE, WR_DONE: begin
                // Chain straight into the slot contents (including one stored this edge)
                state_d = IDLE;
                if (pend_vld_d) begin
                    srv_vld    = 1'b1;
                    srv_wr     = pend_wr_d;
                    srv_addr   = pend_addr_d;
                    srv_data   = pend_data_d;
                    pend_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (srv_vld) begin
            cnt_d = '0;
            if (srv_wr) begin
                state_d = WR_ACCESS;
                addr_d  = WR_BASE + srv_addr;
                wdata_d = srv_data;
            end else begin
                state_d = RD_ACCESS;
                addr_d  = RD_BASE + srv_addr;
            end
        end
    end

    // State and registered outputs; strobes/pulses follow the next state so they align with it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            overrun_q   <= 1'b0;
            ce_q        <= 1'b0;
            oe_q        <= 1'b0;
            wr_q        <= 1'b0;
            rd_cmp_q    <= 1'b0;
            wr_cmp_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            overrun_q   <= overrun_d;
            ce_q        <= (state_d == RD_ACCESS) || (state_d == WR_ACCESS);
            oe_q        <= (state_d == RD_ACCESS);
            wr_q        <= (state_d == WR_ACCESS);
            rd_cmp_q    <= (state_d == RD_DONE);
            wr_cmp_q    <= (state_d == WR_DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign o_read_complete  = rd_cmp_q;
    assign o_rdata          = rdata_q;
    assign o_write_complete = wr_cmp_q;
    assign o_sram_addr      = addr_q;
    assign o_sram_ce        = ce_q;
    assign o_sram_oe        = oe_q;
    assign o_sram_wr        = wr_q;
    assign o_sram_wdata     = wdata_q;
    assign o_overrun        = overrun_q;
    assign o_busy           = busy_q;

endmodule

// File: tb/tb_sram_responder.sv
// Purpose: directed self-checking bench for sram_responder (WAIT_CYCLES=2).
//          A second instance with RD_BASE=2 shares the stimulus for the wrap case.
module tb_sram_responder;

    logic        clk;
    logic        n_rst;
    logic        i_re;
    logic [31:0] i_raddr;
    logic        i_we;
    logic [31:0] i_waddr;
    logic [31:0] i_wdata;
    logic [31:0] i_sram_rdata;

    logic        o_read_complete, o_write_complete;
    logic [31:0] o_rdata, o_sram_addr, o_sram_wdata;
    logic        o_sram_ce, o_sram_oe, o_sram_wr, o_overrun, o_busy;

    logic        w_read_complete, w_write_complete;
    logic [31:0] w_rdata, w_sram_addr, w_sram_wdata;
    logic        w_sram_ce, w_sram_oe, w_sram_wr, w_overrun, w_busy;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned n_spurious;

    sram_responder u_dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_re             (i_re),
        .i_raddr          (i_raddr),
        .i_we             (i_we),
        .i_waddr          (i_waddr),
        .i_wdata          (i_wdata),
        .i_sram_rdata     (i_sram_rdata),
        .o_read_complete  (o_read_complete),
        .o_rdata          (o_rdata),
        .o_write_complete (o_write_complete),
        .o_sram_addr      (o_sram_addr),
        .o_sram_ce        (o_sram_ce),
        .o_sram_oe        (o_sram_oe),
        .o_sram_wr        (o_sram_wr),
        .o_sram_wdata     (o_sram_wdata),
        .o_overrun        (o_overrun),
        .o_busy           (o_busy)
    );

    sram_responder #(.RD_BASE(32'h0000_0002)) u_wrap (
        .clk              (clk),
        .n_rst            (n_rst),
        .i_re             (i_re),
        .i_raddr          (i_raddr),
        .i_we             (i_we),
        .i_waddr          (i_waddr),
        .i_wdata          (i_wdata),
        .i_sram_rdata     (i_sram_rdata),
        .o_read_complete  (w_read_complete),
        .o_rdata          (w_rdata),
        .o_write_complete (w_write_complete),
        .o_sram_addr      (w_sram_addr),
        .o_sram_ce        (w_sram_ce),
        .o_sram_oe        (w_sram_oe),
        .o_sram_wr        (w_sram_wr),
        .o_sram_wdata     (w_sram_wdata),
        .o_overrun        (w_overrun),
        .o_busy           (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_re    = 1'b0;
        i_we    = 1'b0;
        i_raddr = '0;
        i_waddr = '0;
        i_wdata = '0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        n_spurious   = 0;
        n_rst        = 1'b0;
        i_sram_rdata = 32'hA5A5_0001;
        idle_inputs();

        // Reset state
        #12;
        check("rst_busy",  32'(o_busy), 32'd0);
        check("rst_addr",  o_sram_addr, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_strb",  {29'd0, o_sram_ce, o_sram_oe, o_sram_wr}, 32'd0);
        check("rst_ovr",   32'(o_overrun), 32'd0);
        n_rst = 1'b1;
        step();

        // Single read, addr 5
        i_re = 1'b1; i_raddr = 32'd5;
        step();                                   // E0
        idle_inputs();
        check("rd_e0_addr", o_sram_addr, 32'd5);
        check("rd_e0_ceoe", {30'd0, o_sram_ce, o_sram_oe}, 32'd3);
        check("rd_e0_busy", 32'(o_busy), 32'd1);
        check("rd_base2",   w_sram_addr, 32'd7);
        step();                                   // E1
        check("rd_e1_ceoe", {30'd0, o_sram_ce, o_sram_oe}, 32'd3);
        check("rd_e1_cmp",  32'(o_read_complete), 32'd0);
        step();                                   // E2
        check("rd_e2_cmp",  32'(o_read_complete), 32'd1);
        check("rd_e2_data", o_rdata, 32'hA5A5_0001);
        check("rd_e2_ce",   32'(o_sram_ce), 32'd0);
        check("rd_e2_hold", o_sram_addr, 32'd5);
        step();                                   // E3
        check("rd_e3_cmp",  32'(o_read_complete), 32'd0);
        check("rd_e3_busy", 32'(o_busy), 32'd0);

        // Single write, addr 3
        i_we = 1'b1; i_waddr = 32'd3; i_wdata = 32'h0000_00FF;
        step();
        idle_inputs();
        check("wr_e0_addr",  o_sram_addr, 32'h0010_0003);
        check("wr_e0_wdata", o_sram_wdata, 32'h0000_00FF);
        check("wr_e0_strb",  {29'd0, o_sram_ce, o_sram_oe, o_sram_wr}, 32'd5);
        step();
        check("wr_e1_wr",    32'(o_sram_wr), 32'd1);
        step();
        check("wr_e2_cmp",   32'(o_write_complete), 32'd1);
        check("wr_e2_wr",    32'(o_sram_wr), 32'd0);
        step();
        check("wr_e3_cmp",   32'(o_write_complete), 32'd0);

        // Simultaneous read 7 / write 9 in IDLE
        i_re = 1'b1; i_raddr = 32'd7; i_we = 1'b1; i_waddr = 32'd9; i_wdata = 32'h1234;
        step();
        idle_inputs();
        check("sim_e0_addr", o_sram_addr, 32'd7);
        check("sim_e0_oe",   32'(o_sram_oe), 32'd1);
        step();
        step();
        check("sim_e2_rcmp", 32'(o_read_complete), 32'd1);
        check("sim_e2_wcmp", 32'(o_write_complete), 32'd0);
        step();
        check("sim_e3_wr",   32'(o_sram_wr), 32'd1);
        check("sim_e3_addr", o_sram_addr, 32'h0010_0009);
        check("sim_e3_busy", 32'(o_busy), 32'd1);
        step();
        step();
        check("sim_e5_wcmp", 32'(o_write_complete), 32'd1);
        check("sim_ovr",     32'(o_overrun), 32'd0);
        step();

        // Address wrap
        i_re = 1'b1; i_raddr = 32'hFFFF_FFFF;
        step();
        idle_inputs();
        check("wrap_base0", o_sram_addr, 32'hFFFF_FFFF);
        check("wrap_base2", w_sram_addr, 32'h0000_0001);
        step(); step(); step();

        // Write request sampled in RD_DONE is served on the exit edge
        i_re = 1'b1; i_raddr = 32'd10;
        step();
        idle_inputs();
        step(); step();                           // E2: RD_DONE
        check("dn_rcmp", 32'(o_read_complete), 32'd1);
        i_we = 1'b1; i_waddr = 32'd11; i_wdata = 32'd5;
        step();                                   // E3
        idle_inputs();
        check("dn_wr",   32'(o_sram_wr), 32'd1);
        check("dn_addr", o_sram_addr, 32'h0010_000B);
        step(); step();
        check("dn_wcmp", 32'(o_write_complete), 32'd1);
        step();

        // Three back-to-back requests: served, pending, dropped
        i_re = 1'b1; i_raddr = 32'd1;
        step();                                   // E0
        idle_inputs();
        i_we = 1'b1; i_waddr = 32'd2; i_wdata = 32'hBEEF;
        step();                                   // E1: stored
        idle_inputs();
        check("b2b_ovr0", 32'(o_overrun), 32'd0);
        i_re = 1'b1; i_raddr = 32'd3;
        step();                                   // E2: dropped
        idle_inputs();
        check("b2b_ovr1", 32'(o_overrun), 32'd1);
        step();                                   // E3
        check("b2b_wr",   o_sram_addr, 32'h0010_0002);
        check("b2b_wd",   o_sram_wdata, 32'h0000_BEEF);
        step(); step();                           // E5
        check("b2b_wcmp", 32'(o_write_complete), 32'd1);
        step();                                   // E6
        check("b2b_idle", 32'(o_busy), 32'd0);
        step(); step();
        check("b2b_stick", 32'(o_overrun), 32'd1);

        // Reset in the middle of a read
        i_re = 1'b1; i_raddr = 32'd4;
        step();
        idle_inputs();
        check("ra_ce", 32'(o_sram_ce), 32'd1);
        n_rst = 1'b0;
        i_re = 1'b1; i_raddr = 32'd8;
        #1;
        check("ra_async_ce",   32'(o_sram_ce), 32'd0);
        check("ra_async_addr", o_sram_addr, 32'd0);
        check("ra_async_rd",   o_rdata, 32'd0);
        check("ra_async_ovr",  32'(o_overrun), 32'd0);
        check("ra_async_busy", 32'(o_busy), 32'd0);
        step(); step();
        check("ra_hold_busy",  32'(o_busy), 32'd0);
        idle_inputs();
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_read_complete) n_spurious++;
        end
        check("ra_no_cmp", n_spurious, 32'd0);
        i_sram_rdata = 32'h1234_5678;
        i_re = 1'b1; i_raddr = 32'd6;
        step();
        idle_inputs();
        check("ra_next_addr", o_sram_addr, 32'd6);
        step(); step();
        check("ra_next_cmp",  32'(o_read_complete), 32'd1);
        check("ra_next_data", o_rdata, 32'h1234_5678);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: SRAM access cycles per transfer; legal range 1-15.
REQ-002 Parameter RD_BASE, default 32'h0000_0000: byte-free word offset added to every read address.
REQ-003 Parameter WR_BASE, default 32'h0010_0000: word offset added to every write address.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 i_re  input  1  read request pulse from the control unit; sampled on rising edge.
REQ-007 i_raddr  input  32  read word address, valid in the cycle i_re is high.
REQ-008 i_we  input  1  write request pulse from the control unit; sampled on rising edge.
REQ-009 i_waddr  input  32  write word address, valid in the cycle i_we is high.
REQ-010 i_wdata  input  32  write data, valid in the cycle i_we is high.
REQ-011 i_sram_rdata  input  32  SRAM read data bus.
REQ-012 o_read_complete  output  1  one-cycle pulse: o_rdata valid.
REQ-013 o_rdata  output  32  last captured read word; held until the next capture.
REQ-014 o_write_complete  output  1  one-cycle pulse: write committed.
REQ-015 o_sram_addr  output  32  SRAM word address.
REQ-016 o_sram_ce / o_sram_oe / o_sram_wr  output  1 each  chip enable, output enable, write strobe; active-high.
REQ-017 o_sram_wdata  output  32  SRAM write data.
REQ-018 o_overrun  output  1  sticky: a request was dropped.
REQ-019 o_busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, RD_ACCESS, RD_DONE, WR_ACCESS, WR_DONE.
REQ-021 IDLE: i_re=1 -> latch i_raddr, go RD_ACCESS; else i_we=1 -> latch i_waddr/i_wdata, go WR_ACCESS; else stay.
REQ-022 IDLE with i_re=1 and i_we=1 same edge: read served first; write stored in the pending slot.
REQ-023 RD_ACCESS: o_sram_ce=o_sram_oe=1, o_sram_addr=RD_BASE+latched addr (32-bit modulo); held exactly WAIT_CYCLES cycles via 4-bit wait counter cleared on entry.
REQ-024 On the final RD_ACCESS edge: o_rdata <= i_sram_rdata, go RD_DONE.
REQ-025 RD_DONE: o_read_complete=1 for exactly one cycle; SRAM strobes low.
REQ-026 WR_ACCESS: o_sram_ce=o_sram_wr=1, o_sram_addr=WR_BASE+latched addr (modulo 2^32), o_sram_wdata=latched data; held exactly WAIT_CYCLES cycles, then WR_DONE.
REQ-027 WR_DONE: o_write_complete=1 for exactly one cycle.
REQ-028 Latency: request sampled at edge E0 -> complete pulse high between edges E(WAIT_CYCLES) and E(WAIT_CYCLES+1).
REQ-029 Outside ACCESS states: o_sram_ce/oe/wr=0; o_sram_addr and o_sram_wdata hold last latched values.
REQ-030 Pending slot (one entry: type, addr, data): request sampled in any non-IDLE state is stored if slot empty.
REQ-031 Request sampled while slot full, or i_re and i_we both high while slot not empty: extra request(s) dropped, o_overrun<=1.
REQ-032 i_re and i_we both high in a non-IDLE state with slot empty: read stored, write dropped, o_overrun<=1.
REQ-033 RD_DONE/WR_DONE exit: slot valid -> go directly to matching ACCESS state with slot contents, clear slot (no IDLE cycle); else IDLE.
REQ-034 Request sampled in a DONE cycle while slot empty: stored, then served per REQ-033 on the same edge.
REQ-035 o_read_complete and o_write_complete never high in the same cycle.
REQ-036 o_busy = (state != IDLE).

Reset
REQ-037 n_rst low: state=IDLE, pending slot empty, wait counter=0, o_rdata=0, o_sram_addr=0, o_sram_wdata=0, all strobes/pulses=0, o_overrun=0, immediately and asynchronously.
REQ-038 Reset mid-access: access aborted, no complete pulse issued, requests during reset ignored.
REQ-039 o_overrun clears only on reset.

Verification
REQ-040 Single read, WAIT_CYCLES=2: i_re, i_raddr=5, SRAM returns 32'hA5A5_0001 -> o_sram_addr=5 with ce/oe 2 cycles, o_rdata=32'hA5A5_0001, o_read_complete high cycle E2-E3.
REQ-041 Single write: i_we, i_waddr=3, i_wdata=32'h0000_00FF -> o_sram_addr=32'h0010_0003, wr high 2 cycles, o_write_complete one pulse.
REQ-042 Simultaneous i_re(addr 7)/i_we(addr 9) in IDLE -> read completes, then write access starts next edge with no IDLE cycle; o_overrun=0.
REQ-043 Three requests back-to-back while busy -> first served, second pending, third dropped, o_overrun=1 and stays 1.
REQ-044 Address wrap: read i_raddr=32'hFFFF_FFFF with RD_BASE=2 -> o_sram_addr=32'h0000_0001.
REQ-045 n_rst low during RD_ACCESS -> all outputs 0 asynchronously, no o_read_complete after release, next i_re served normally.
